// File: rtl/note_judge_ctrl.sv
// Lane note-chart sequencer: keeps the song clock, judges presses/releases
// against the head chart entry, advances the ROM pointer and accumulates score.
module note_judge_ctrl #(
   parameter logic [13:0] PERFECT_W = 14'd3,
   parameter logic [13:0] GOOD_W    = 14'd8,
   parameter logic [15:0] END_WORD  = 16'h16D3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic        pause,
   input  logic        tick,
   input  logic        key_down,
   input  logic [15:0] key_1,
   output logic [7:0]  addr,
   output logic [13:0] song_time,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic [15:0] score,
   output logic [9:0]  combo,
   output logic [9:0]  max_combo,
   output logic        holding,
   output logic        done,
   output logic [1:0]  fsm_state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HOLD = 2'd2, S_DONE = 2'd3} state_t;
   localparam logic [1:0] J_PERFECT = 2'b01;
   localparam logic [1:0] J_GOOD    = 2'b10;
   localparam logic [1:0] J_MISS    = 2'b11;

   state_t             state, state_nx;
   logic               key_prev;
   logic [7:0]         addr_nx;
   logic [13:0]        time_nx;
   logic               jv_nx;
   logic [1:0]         jc_nx;
   logic [15:0]        score_nx;
   logic [9:0]         combo_nx, max_nx;
   logic [16:0]        score_sum;
   logic signed [14:0] diff;
   logic [14:0]        mag;
   logic               press, key_rel, early, late;
   logic [1:0]         win_code;

   // Edges are taken against the previous cycle's level even while paused,
   // so a paused edge is consumed rather than deferred.
   assign press    = key_down & ~key_prev;
   assign key_rel  = ~key_down & key_prev;
   assign diff     = $signed({1'b0, song_time}) - $signed({1'b0, key_1[13:0]});
   assign mag      = diff[14] ? $unsigned(-diff) : $unsigned(diff);
   assign early    = diff[14] & (mag > {1'b0, GOOD_W});
   assign late     = ~diff[14] & (mag > {1'b0, GOOD_W});
   assign win_code = (mag <= {1'b0, PERFECT_W}) ? J_PERFECT : J_GOOD;

   always_comb begin
      state_nx  = state;
      addr_nx   = addr;
      time_nx   = song_time;
      jv_nx     = 1'b0;
      jc_nx     = 2'b00;
      score_nx  = score;
      combo_nx  = combo;
      max_nx    = max_combo;
      score_sum = 17'd0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_PLAY;
               addr_nx  = 8'd0;
               time_nx  = 14'd0;
               score_nx = 16'd0;
               combo_nx = 10'd0;
               max_nx   = 10'd0;
            end
         end
         S_PLAY: begin
            if (!pause) begin
               if (key_1 == END_WORD) begin
                  state_nx = S_DONE;
               end else if (key_1[15:14] == 2'b10) begin
                  addr_nx = addr + 8'd1;
               end else if (late) begin
                  // A missed hold start also drops its paired release entry.
                  jv_nx   = 1'b1;
                  jc_nx   = J_MISS;
                  addr_nx = (key_1[15:14] == 2'b01) ? addr + 8'd2 : addr + 8'd1;
               end else if (press && !early) begin
                  jv_nx   = 1'b1;
                  jc_nx   = win_code;
                  addr_nx = addr + 8'd1;
                  if (key_1[15:14] == 2'b01) state_nx = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!pause) begin
               if (late) begin
                  jv_nx    = 1'b1;
                  jc_nx    = J_GOOD;
                  addr_nx  = addr + 8'd1;
                  state_nx = S_PLAY;
               end else if (key_rel) begin
                  jv_nx    = 1'b1;
                  jc_nx    = early ? J_MISS : win_code;
                  addr_nx  = addr + 8'd1;
                  state_nx = S_PLAY;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      if ((state == S_PLAY || state == S_HOLD) && !pause && tick && song_time != 14'h3FFF)
         time_nx = song_time + 14'd1;

      if (jv_nx) begin
         if (jc_nx == J_MISS) begin
            combo_nx = 10'd0;
         end else begin
            if (combo != 10'h3FF) combo_nx = combo + 10'd1;
            score_sum = {1'b0, score} + ((jc_nx == J_PERFECT) ? 17'd3 : 17'd1);
            score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         end
         if (combo_nx > max_combo) max_nx = combo_nx;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= S_IDLE;
         key_prev    <= 1'b0;
         addr        <= 8'd0;
         song_time   <= 14'd0;
         judge_valid <= 1'b0;
         judge_code  <= 2'b00;
         score       <= 16'd0;
         combo       <= 10'd0;
         max_combo   <= 10'd0;
      end else begin
         state       <= state_nx;
         key_prev    <= key_down;
         addr        <= addr_nx;
         song_time   <= time_nx;
         judge_valid <= jv_nx;
         judge_code  <= jc_nx;
         score       <= score_nx;
         combo       <= combo_nx;
         max_combo   <= max_nx;
      end
   end

   assign holding   = (state == S_HOLD);
   assign done      = (state == S_DONE);
   assign fsm_state = state;
endmodule

// File: tb/tb_note_judge_ctrl.sv
// Bench for note_judge_ctrl: table of single-press timings, directed
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_note_judge_ctrl;
   localparam logic [15:0] END_W = 16'h16D3;
   localparam int PW = 3;
   localparam int GW = 8;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        start = 1'b0, pause = 1'b0, tick = 1'b0, key_down = 1'b0;
   logic [15:0] key_1;
   logic [7:0]  addr;
   logic [13:0] song_time;
   logic        judge_valid;
   logic [1:0]  judge_code;
   logic [15:0] score;
   logic [9:0]  combo, max_combo;
   logic        holding, done;
   logic [1:0]  fsm_state;
   logic [15:0] rom [0:255];
   int          n_pass = 0;
   int          n_checks = 0;

   assign key_1 = rom[addr];

   note_judge_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .pause(pause), .tick(tick),
      .key_down(key_down), .key_1(key_1), .addr(addr), .song_time(song_time),
      .judge_valid(judge_valid), .judge_code(judge_code), .score(score),
      .combo(combo), .max_combo(max_combo), .holding(holding), .done(done),
      .fsm_state(fsm_state)
   );

   always #5 Clk = ~Clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = END_W;
   endtask

   task automatic do_reset();
      start = 1'b0; pause = 1'b0; tick = 1'b0; key_down = 1'b0;
      Reset_n = 1'b0;
      cyc(); cyc();
      Reset_n = 1'b1;
      cyc();
   endtask

   task automatic begin_play();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic tick_n(input int n);
      tick = 1'b1;
      repeat (n) cyc();
      tick = 1'b0;
   endtask

   task automatic press();
      key_down = 1'b1; cyc();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_addr"}, int'(addr), 0);
      chk({tag, "_time"}, int'(song_time), 0);
      chk({tag, "_jv"}, int'(judge_valid), 0);
      chk({tag, "_jc"}, int'(judge_code), 0);
      chk({tag, "_score"}, int'(score), 0);
      chk({tag, "_combo"}, int'(combo), 0);
      chk({tag, "_max"}, int'(max_combo), 0);
      chk({tag, "_holding"}, int'(holding), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   // ---------------- behavioural reference model ----------------
   int m_mode;   // 0 idle, 1 playing, 2 holding, 3 finished
   int m_addr, m_time, m_score, m_combo, m_max, m_jc;
   bit m_key;

   function automatic int grade(input int d);
      int a;
      a = (d < 0) ? -d : d;
      return (a <= PW) ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_addr = 0; m_time = 0; m_score = 0; m_combo = 0; m_max = 0;
      m_jc = 0; m_key = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] head;
      int d, code;
      bit pr, rl;
      head = rom[m_addr];
      d    = m_time - int'(head[13:0]);
      pr   = key_down && !m_key;
      rl   = !key_down && m_key;
      code = 0;
      if ((m_mode == 0 || m_mode == 3) && start) begin
         m_mode = 1; m_addr = 0; m_time = 0; m_score = 0; m_combo = 0; m_max = 0;
      end else if ((m_mode == 1 || m_mode == 2) && !pause) begin
         if (m_mode == 1) begin
            if (head == END_W) m_mode = 3;
            else if (head[15:14] == 2'b10) m_addr += 1;
            else if (d > GW) begin
               code = 3;
               m_addr += (head[15:14] == 2'b01) ? 2 : 1;
            end else if (pr && d >= -GW) begin
               code = grade(d);
               m_addr += 1;
               if (head[15:14] == 2'b01) m_mode = 2;
            end
         end else begin
            if (d > GW) begin
               code = 2; m_addr += 1; m_mode = 1;
            end else if (rl) begin
               code = (d < -GW) ? 3 : grade(d);
               m_addr += 1; m_mode = 1;
            end
         end
         if (tick && m_time < 16383) m_time++;
      end
      m_key = key_down;
      m_jc  = code;
      if (code == 3) m_combo = 0;
      else if (code != 0) begin
         m_combo = (m_combo < 1023) ? m_combo + 1 : 1023;
         m_score = m_score + ((code == 1) ? 3 : 1);
         if (m_score > 65535) m_score = 65535;
      end
      if (m_combo > m_max) m_max = m_combo;
   endtask

   task automatic gen_chart();
      int t, i, r;
      t = 10; i = 0;
      clear_rom();
      while (i < 24) begin
         r = int'($urandom_range(0, 9));
         t += int'($urandom_range(3, 12));
         if (r < 6) begin
            rom[i] = {(r % 2 == 1) ? 2'b11 : 2'b00, 14'(t)};
            i++;
         end else if (r < 9) begin
            rom[i] = {2'b01, 14'(t)};
            t += int'($urandom_range(5, 20));
            rom[i + 1] = {2'b10, 14'(t)};
            i += 2;
         end else begin
            rom[i] = {2'b10, 14'(t)};
            i++;
         end
      end
   endtask

   // ---------------- single-press timing table ----------------
   typedef struct {
      int press_t;
      bit exp_v;
      int exp_code;
      int exp_score;
      int exp_addr;
   } vec_t;
   vec_t vecs[10];

   initial begin
      int cnt;
      bit regen;
      vecs[0] = '{168, 1'b1, 1, 3, 1};
      vecs[1] = '{150, 1'b0, 0, 0, 0};
      vecs[2] = '{161, 1'b1, 2, 1, 1};
      vecs[3] = '{165, 1'b1, 1, 3, 1};
      vecs[4] = '{164, 1'b1, 2, 1, 1};
      vecs[5] = '{171, 1'b1, 1, 3, 1};
      vecs[6] = '{172, 1'b1, 2, 1, 1};
      vecs[7] = '{176, 1'b1, 2, 1, 1};
      vecs[8] = '{160, 1'b1, 2, 1, 1};
      vecs[9] = '{159, 1'b0, 0, 0, 0};

      clear_rom();
      do_reset();
      check_zero("reset");

      for (int v = 0; v < 10; v++) begin
         clear_rom();
         rom[0] = 16'h00A8;
         do_reset();
         begin_play();
         tick_n(vecs[v].press_t);
         press();
         chk($sformatf("tab%0d_jv", v), int'(judge_valid), int'(vecs[v].exp_v));
         chk($sformatf("tab%0d_jc", v), int'(judge_code), vecs[v].exp_code);
         chk($sformatf("tab%0d_score", v), int'(score), vecs[v].exp_score);
         chk($sformatf("tab%0d_combo", v), int'(combo), int'(vecs[v].exp_v));
         chk($sformatf("tab%0d_addr", v), int'(addr), vecs[v].exp_addr);
      end

      // Auto MISS after a combo of five
      clear_rom();
      for (int i = 0; i < 5; i++) rom[i] = 16'(10 * (i + 1));
      rom[5] = 16'h00A8;
      do_reset();
      begin_play();
      for (int i = 0; i < 5; i++) begin
         tick_n(10);
         press();
         key_down = 1'b0;
      end
      chk("combo5_combo", int'(combo), 5);
      chk("combo5_score", int'(score), 15);
      tick_n(127);
      chk("miss_pre_jv", int'(judge_valid), 0);
      cyc();
      chk("miss_jv", int'(judge_valid), 1);
      chk("miss_jc", int'(judge_code), 3);
      chk("miss_combo", int'(combo), 0);
      chk("miss_max", int'(max_combo), 5);
      chk("miss_addr", int'(addr), 6);

      // Hold: press at 100, release at 141
      clear_rom(); rom[0] = 16'h4064; rom[1] = 16'h808C;
      do_reset(); begin_play(); tick_n(100);
      press();
      chk("hold_a_jc1", int'(judge_code), 1);
      chk("hold_a_holding1", int'(holding), 1);
      chk("hold_a_addr1", int'(addr), 1);
      tick_n(41);
      key_down = 1'b0; cyc();
      chk("hold_a_jv2", int'(judge_valid), 1);
      chk("hold_a_jc2", int'(judge_code), 1);
      chk("hold_a_score", int'(score), 6);
      chk("hold_a_addr2", int'(addr), 2);
      chk("hold_a_holding2", int'(holding), 0);

      // Hold: early release at 120
      do_reset(); begin_play(); tick_n(100);
      press();
      tick_n(20);
      key_down = 1'b0; cyc();
      chk("hold_b_jc", int'(judge_code), 3);
      chk("hold_b_combo", int'(combo), 0);
      chk("hold_b_max", int'(max_combo), 1);
      chk("hold_b_addr", int'(addr), 2);

      // Hold start never pressed: single MISS, pointer skips the pair
      do_reset(); begin_play(); tick_n(109);
      cyc();
      chk("hold_c_jc", int'(judge_code), 3);
      chk("hold_c_addr", int'(addr), 2);
      cyc();
      chk("hold_c_single", int'(judge_valid), 0);

      // Hold kept past the release window: auto GOOD
      do_reset(); begin_play(); tick_n(100);
      press();
      tick_n(49);
      cyc();
      chk("hold_d_jc", int'(judge_code), 2);
      chk("hold_d_score", int'(score), 4);
      chk("hold_d_holding", int'(holding), 0);
      chk("hold_d_addr", int'(addr), 2);

      // Pause: clock frozen, paused press consumed
      clear_rom(); rom[0] = 16'h00C8;
      do_reset(); begin_play(); tick_n(200);
      pause = 1'b1; tick = 1'b1; cnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) key_down = 1'b1;
         cyc();
         if (judge_valid) cnt++;
      end
      tick = 1'b0;
      chk("pause_time", int'(song_time), 200);
      chk("pause_pulses", cnt, 0);
      pause = 1'b0; cyc();
      chk("pause_consumed", int'(judge_valid), 0);
      key_down = 1'b0; cyc();
      press();
      chk("pause_after_jc", int'(judge_code), 1);

      // Chart end at addr 4, frozen, then restart
      clear_rom();
      for (int i = 0; i < 4; i++) rom[i] = 16'(10 * (i + 1));
      do_reset(); begin_play();
      for (int i = 0; i < 4; i++) begin
         tick_n(10);
         press();
         key_down = 1'b0;
      end
      chk("end_addr4", int'(addr), 4);
      cyc();
      chk("end_done", int'(done), 1);
      tick_n(5);
      press();
      chk("end_addr_held", int'(addr), 4);
      chk("end_time_held", int'(song_time), 40);
      chk("end_no_judge", int'(judge_valid), 0);
      chk("end_score", int'(score), 12);
      key_down = 1'b0;
      begin_play();
      chk("restart_done", int'(done), 0);
      chk("restart_addr", int'(addr), 0);
      chk("restart_score", int'(score), 0);
      chk("restart_max", int'(max_combo), 0);

      // Song clock saturation
      clear_rom(); rom[0] = 16'h3FFF;
      do_reset(); begin_play(); tick_n(16390);
      chk("sat_time", int'(song_time), 16383);
      press();
      chk("sat_jc", int'(judge_code), 1);

      // Asynchronous reset mid-hold
      clear_rom(); rom[0] = 16'h4064; rom[1] = 16'h808C;
      do_reset(); begin_play(); tick_n(100);
      press();
      chk("rst_pre_holding", int'(holding), 1);
      #1;
      Reset_n = 1'b0;
      #1;
      check_zero("rst_async");
      cyc();
      Reset_n = 1'b1;

      // Randomized run against the model
      gen_chart();
      do_reset();
      model_reset();
      regen = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         if (m_mode == 3 && !regen) begin
            gen_chart();
            regen = 1'b1;
         end
         if (m_mode == 1) regen = 1'b0;
         start = ($urandom_range(0, 99) < 3);
         tick  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) pause = ~pause;
         if ($urandom_range(0, 5) == 0) key_down = ~key_down;
         model_step();
         cyc();
         chk("rnd_addr", int'(addr), m_addr);
         chk("rnd_time", int'(song_time), m_time);
         chk("rnd_jv", int'(judge_valid), (m_jc != 0) ? 1 : 0);
         chk("rnd_jc", int'(judge_code), m_jc);
         chk("rnd_score", int'(score), m_score);
         chk("rnd_combo", int'(combo), m_combo);
         chk("rnd_max", int'(max_combo), m_max);
         chk("rnd_holding", int'(holding), (m_mode == 2) ? 1 : 0);
         chk("rnd_done", int'(done), (m_mode == 3) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/note_judge_ctrl.md
# note_judge_ctrl

Sequencing controller for the lane note-chart ROM (16-bit entries: [15:14] note type, [13:0] timestamp). It keeps the song clock and owns the chart read pointer `addr`. It judges player presses and releases against the head note, advances the pointer, and accumulates score and combo for the HUD and game FSM. The ROM's four-entry window `key_1..key_4` returns to the renderer unchanged. `key_1` is always the head, the oldest unjudged note.

## Interface
- `PERFECT_W`, default 14'd3: half-width of the PERFECT window, in time units.
- `GOOD_W`, default 14'd8: half-width of the GOOD window, in time units. Must be ≥ PERFECT_W.
- `END_WORD`, default 16'h16D3: chart terminator word.

- `Clk`, in, 1: system clock. Single clock domain.
- `Reset_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: pulse. Begins play from IDLE or DONE.
- `pause`, in, 1: level. Freezes the song clock and all judgement.
- `tick`, in, 1: one-cycle strobe per time unit.
- `key_down`, in, 1: player key level, already synchronous to `Clk`.
- `key_1`, in, 16: head chart entry from the ROM. Combinational, valid in the same cycle as `addr`.
- `addr`, out, 8: chart ROM index.
- `song_time`, out, 14: current time in time units.
- `judge_valid`, out, 1: one-cycle pulse on each judgement.
- `judge_code`, out, 2: 00 none, 01 PERFECT, 10 GOOD, 11 MISS. Valid with `judge_valid`.
- `score`, out, 16: accumulated score.
- `combo`, out, 10: current combo.
- `max_combo`, out, 10: highest combo reached.
- `holding`, out, 1: high while a hold note is active.
- `done`, out, 1: chart finished.

## Operation
- **States:** IDLE, PLAY, HOLD, DONE. Reset enters IDLE.
- **Reset values:** all outputs 0.
- **IDLE:** `addr`=0 and `song_time`=0. `start` goes to PLAY and clears `score`, `combo` and `max_combo`.
- **Song clock:** in PLAY and HOLD with `pause`=0, each `tick` increments `song_time`. It saturates at 16383.
- **Edge detection:** a registered copy of `key_down` is kept. A press is 0→1 and a release is 1→0. Edges that occur while paused are consumed and never judged.
- **Timing error:** t = `key_1[13:0]`. The signed 15-bit difference d = `song_time` − t uses the registered `song_time` from before any same-cycle tick.
- **Window classification:** |d| ≤ PERFECT_W gives PERFECT. Otherwise |d| ≤ GOOD_W gives GOOD.
- **PLAY, head type 00 or 11 (tap):**
  - Press with d < −GOOD_W: ignored.
  - Press inside a window: judged, `addr`+1.
  - Late: when d > GOOD_W, MISS is issued automatically and `addr`+1.
- **PLAY, head type 01 (hold start):**
  - Press inside a window: judged, `addr`+1, go to HOLD.
  - Late MISS: `addr`+2, skipping the paired 10 entry. Only one MISS is reported.
- **PLAY, head type 10 (orphan hold end):** silently skipped, `addr`+1, no judgement.
- **HOLD (head is type 10, `holding`=1):**
  - Release inside a window: judged.
  - Release with d < −GOOD_W: MISS.
  - Still held when d > GOOD_W: GOOD.
  - In all three cases `addr`+1, then return to PLAY.
- **Chart end:** in PLAY, when `key_1` == END_WORD, go to DONE with `done`=1. `addr` and `song_time` are frozen. `start` in DONE restarts exactly as from IDLE. `start` is ignored in PLAY and HOLD.
- **Scoring:**
  - PERFECT adds 3 to `score` and GOOD adds 1. `score` saturates at 65535.
  - PERFECT or GOOD increments `combo`, saturating at 1023. MISS clears `combo`.
  - `max_combo` = max(`max_combo`, new `combo`).
- **Same-cycle priority:** an auto-MISS or auto-GOOD timeout beats a key edge in the same cycle. The edge is then discarded.
- **Judgement rate:** at most one judgement per cycle.

## Timing
- Edge sampled at cycle N → `judge_valid`, `judge_code`, `addr`, `score` and `combo` update at the N+1 clock edge. They are visible during cycle N+1.
- The new head `key_1` is valid during N+1. The next judgement pulses no earlier than N+2.
- An auto-MISS fires on the edge after d first exceeds GOOD_W.
- `done` rises on the edge after END_WORD is seen at the head.
- `Reset_n` low forces IDLE and zeros every output immediately, in any state including HOLD.
- `addr` never advances past the END_WORD entry.

## Test plan
- Chart starting 16'h00A8 (t=168): start, tick to 168, press → `judge_valid`, PERFECT, `score`=3, `combo`=1, `addr`=1.
- Head t=168: press at 150 → no pulse. Press at 161 (d=−7) → GOOD, `score`=1.
- Head t=168, no press: at `song_time`=177 → MISS, `combo` 5→0, `max_combo` stays 5, `addr`+1.
- Synthetic hold pair 16'h4064 (t=100) / 16'h808C (t=140):
  - Press at 100, release at 141 → two PERFECT, `score`=6, `addr`+2, `holding` 1 then 0.
  - Release at 120 instead → MISS.
- Pause at 200 for 50 ticks → `song_time` stays 200. A press during the pause produces no judgement.
- END_WORD at `addr`=4 → `done`=1, `addr` held at 4. `Reset_n` pulsed low mid-HOLD → all outputs 0 within the same cycle.
